// File: rtl/display_driver_pkg.sv
// Shared definitions for the BCM display scan controller: FSM encoding,
// bit-plane weighting and timer sizing.
package display_driver_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StBlank,
        StLatch,
        StShow
    } state_t;

    // On-period in cycles of bit-plane p.
    function automatic int unsigned plane_weight(input int unsigned base_time,
                                                 input int unsigned p);
        return base_time << p;
    endfunction

    // Wide enough to hold base_time << (bit_depth - 1).
    function automatic int unsigned timer_width(input int unsigned base_time,
                                                input int unsigned bit_depth);
        return $clog2(base_time) + bit_depth;
    endfunction

endpackage

// File: rtl/display_driver_bcm_timer.sv
// Loadable down-counter that times one bit-plane on-period and owns the
// panel blanking output: unblanked from load until the count reaches zero.
module display_driver_bcm_timer #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] value,
    output logic             zero,
    output logic             blank
);

    logic [width-1:0] count;

    // Load on start, otherwise count down to zero and re-blank on the final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            blank <= 1'b1;
        end else if (start) begin
            count <= value;
            blank <= (value == '0);
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (count == width'(1)) begin
                blank <= 1'b1;
            end
        end
    end

    // Zero flag lets the scan FSM wait for the current on-period to expire.
    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/display_driver_scan_controller.sv
// Multiplexed LED panel scan controller with binary-code modulation.
// Loads the next row/plane while the current one is displayed, then
// blanks, latches and shows it for base_time << plane cycles.
module display_driver_scan_controller
    import display_driver_pkg::*;
#(
    parameter int unsigned rows      = 16,
    parameter int unsigned bit_depth = 4,
    parameter int unsigned base_time = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              enable,
    output logic                                              load,
    input  logic                                              complete,
    output logic                                              latch,
    output logic                                              blank,
    output logic [$clog2(rows)-1:0]                           row,
    output logic [$clog2(rows)-1:0]                           load_row,
    output logic [((bit_depth > 1) ? $clog2(bit_depth) : 1)-1:0] load_plane,
    output logic                                              frame
);

    localparam int unsigned row_w   = $clog2(rows);
    localparam int unsigned plane_w = (bit_depth > 1) ? $clog2(bit_depth) : 1;
    localparam int unsigned timer_w = timer_width(base_time, bit_depth);

    localparam logic [row_w-1:0]   last_row   = row_w'(rows - 1);
    localparam logic [plane_w-1:0] last_plane = plane_w'(bit_depth - 1);

    state_t               state;
    logic                 timer_start;
    logic                 timer_zero;
    logic [timer_w-1:0]   timer_value;

    // The timer is loaded while in SHOW, using the plane that was just latched.
    always_comb begin
        timer_start = (state == StShow);
        timer_value = timer_w'(plane_weight(base_time, 32'(load_plane)));
    end

    display_driver_bcm_timer #(
        .width (timer_w)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .value (timer_value),
        .zero  (timer_zero),
        .blank (blank)
    );

    // Scan FSM, row/plane counters and loader handshake with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            load       <= 1'b0;
            latch      <= 1'b0;
            row        <= '0;
            load_row   <= '0;
            load_plane <= '0;
            frame      <= 1'b0;
        end else begin
            latch <= 1'b0;
            frame <= 1'b0;
            case (state)
                StIdle: begin
                    if (enable) begin
                        state <= StLoad;
                        load  <= 1'b1;
                    end
                end
                StLoad: begin
                    if (complete) begin
                        state <= StWait;
                        load  <= 1'b0;
                    end
                end
                StWait: begin
                    // Row address changes only once the panel is blanked again.
                    if (timer_zero) begin
                        state <= StBlank;
                        row   <= load_row;
                    end
                end
                StBlank: begin
                    state <= StLatch;
                    latch <= 1'b1;
                end
                StLatch: begin
                    state <= StShow;
                    // Frame pulse lines up with the SHOW of the last row and plane.
                    frame <= (load_row == last_row) && (load_plane == last_plane);
                end
                StShow: begin
                    if (load_plane == last_plane) begin
                        load_plane <= '0;
                        load_row   <= (load_row == last_row) ? '0 : load_row + 1'b1;
                    end else begin
                        load_plane <= load_plane + 1'b1;
                    end
                    if (enable) begin
                        state <= StLoad;
                        load  <= 1'b1;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/display_driver_scan_controller.md
# display_driver_scan_controller

Sequences a multiplexed LED panel for one refresh frame at a time, using binary-code modulation (BCM) for brightness. It drives the row loader's `load` and watches its `complete` pulse. It issues `latch`, `blank` and the row address, and times each bit-plane's on-period so that plane p is displayed for base_time·2^p cycles. Loading of the next row/plane overlaps display of the current one. The block sits between the frame buffer read logic, which consumes `load_row`/`load_plane`, and the panel pins.

## Interface
- `rows`, 16, panel scan rows; must be ≥2.
- `bit_depth`, 4, bit-planes per pixel; must be ≥1.
- `base_time`, 64, display cycles of plane 0; must be ≥1.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  runs scanning while high.
- `load`  out  1  to the row loader; held high until `complete` is seen.
- `complete`  in  1  single-cycle pulse from the row loader marking the end of a row shift.
- `latch`  out  1  panel latch strobe.
- `blank`  out  1  panel output-enable, active-high blanking.
- `row`  out  clog2(rows)  panel row address currently displayed.
- `load_row`  out  clog2(rows)  row being shifted in.
- `load_plane`  out  clog2(bit_depth) (min 1)  plane being shifted in.
- `frame`  out  1  single-cycle pulse when the last row/plane of a frame is latched.

## Operation
- Reset values: state IDLE, `load`=0, `latch`=0, `blank`=1, `row`=0, `load_row`=0, `load_plane`=0, `frame`=0, timer=0. All outputs are registered.
- Scan order: for each row 0..rows-1, show planes 0..bit_depth-1. After the last plane of the last row, wrap to row 0, plane 0.
- IDLE: if `enable`=1, go to LOAD.
- LOAD: `load`=1. On the cycle `complete`=1, drop `load` on the next edge and go to WAIT.
  - `load` must be low the cycle after `complete`; the loader restarts if `load` stays high.
- WAIT: stay while timer≠0.
- BLANK: one cycle. `row`←`load_row`.
- LATCH: one cycle, `latch`=1.
- SHOW: one cycle.
  - timer←base_time<<`load_plane`, and `blank` goes low on the next edge.
  - Advance `load_plane`. On wrap, advance `load_row`. On `load_row` wrap, pulse `frame`.
  - Next state is LOAD if `enable`=1, else IDLE.
- Timer:
  - Decrements by 1 each cycle while non-zero.
  - `blank`←1 on the edge where the timer reaches 0, so the display is unblanked for exactly base_time·2^p cycles.
  - Width is clog2(base_time)+bit_depth bits; no overflow is possible.
- If the load is slower than the current on-period, the panel stays blanked until the next SHOW. Brightness ratios still hold; only the duty cycle drops.
- `enable` falling is honoured only in IDLE or at SHOW exit. An in-progress load/latch always completes, and the final on-period runs to expiry, then `blank`=1.
- `rst` mid-operation: outputs return to their reset values immediately. `load` drops asynchronously, so the row loader sees `load`=0 and resets itself.
- `complete` outside LOAD is ignored.

## Timing
- Entering BLANK to `latch` high: 1 cycle.
- `latch` high to `blank` low: 2 cycles. The SHOW edge loads the timer; `blank` falls on that same edge.
- Minimum per-plane period: load time + 3 cycles (BLANK, LATCH, SHOW), or base_time·2^p + 3 cycles, whichever is longer.
- `load` rises the cycle after SHOW, in parallel with the on-period.
- `frame` is coincident with the SHOW cycle of the last row and last plane.

## Structure
- Shared package `display_driver_pkg` holds:
  - the state encoding (IDLE, LOAD, WAIT, BLANK, LATCH, SHOW);
  - a `plane_weight(base_time, p)` constant function;
  - the timer-width calculation.
- One sub-module, `display_driver_bcm_timer`: loadable down-counter with a `zero` flag and a registered `blank` output.
- The FSM, row/plane counters and handshake live in the top module.

## Test plan
Parameters: rows=4, bit_depth=2, base_time=8. The bench model returns `complete` 40 cycles after `load` rises.

1. Reset
   - Stimulus: assert `rst` mid-LOAD.
   - Required: `load`=0, `blank`=1, `row`=0 with no clock edge; after release, IDLE until `enable`.
2. Weighting
   - Stimulus: `enable`=1 for a full frame.
   - Required: `blank` low runs of exactly 8 and 16 cycles, alternating.
   - Required: `row` sequence 0,0,1,1,2,2,3,3.
   - Required: `frame` pulses once, on the row 3 plane 1 SHOW.
3. Handshake
   - Required: `load` falls the cycle after `complete`, and never stays high past a `complete`.
   - Required: exactly one `latch` per `complete`.
4. Slow loader
   - Stimulus: base_time=8, `complete` delay 40.
   - Required: `blank` low runs remain exactly 8/16 cycles; blank gaps grow.
5. Fast loader
   - Stimulus: `complete` after 2 cycles.
   - Required: WAIT holds until the timer is 0.
   - Required: `latch` occurs only with `blank`=1, exactly 1 cycle after `row` updates.
6. Stop
   - Stimulus: drop `enable` during LOAD of row 2 plane 0.
   - Required: that plane is latched and shown for 8 cycles, then `blank`=1, state IDLE, `load`=0.
